sobel_px_packer: RTL
====================

Name: sobel_px_packer

Overview:
- Downstream stage of the gray/sobel top: consumes the single-pixel output stream (out_pixel_o low byte qualified by px_ready_sobel_o) and packs LANES pixels into one bus word.
- Buffers packed words in a small FIFO and presents them on a valid/ready word interface for a DMA/bus writer.
- Frames are delimited by the same start/finish strobes that drive the core; finish flushes a partial word tagged last.

Parameters:
- PIXEL_W, 8: width of one packed pixel (low PIXEL_W bits of the core output).
- LANES, 4: pixels per output word; word width = PIXEL_W*LANES.
- FIFO_DEPTH, 8: word FIFO entries; power of 2, at least 2.
- CNT_W, 20: width of the accepted-pixel counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  frame start strobe, shared with the core.
- finish_i  in  1  frame end strobe, shared with the core.
- px_valid_i  in  1  pixel qualifier (core px_ready output).
- px_i  in  PIXEL_W  pixel data.
- word_o  out  PIXEL_W*LANES  packed word; lane 0 (first pixel) in bits [PIXEL_W-1:0].
- word_keep_o  out  LANES  per-lane valid mask.
- word_last_o  out  1  final word of frame.
- word_valid_o  out  1  FIFO head valid.
- word_ready_i  in  1  downstream accept.
- busy_o  out  1  state != IDLE.
- overflow_o  out  1  sticky; a pixel or word was dropped this frame.
- px_count_o  out  CNT_W  pixels accepted this frame, saturating.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are 0; FIFO is emptied; lane counter, pack register, counter and overflow are cleared; state is IDLE. Reset mid-frame discards all buffered data.
- FSM states:
  - IDLE: pixels are ignored. start_i moves to RUN, clears px_count_o, overflow_o and the lane count.
  - RUN: on each px_valid_i, px_i is written into lane lane_cnt. When lane_cnt == LANES-1, the completed word is pushed with keep all-ones and last=0 in the same cycle, and lane_cnt wraps to 0. finish_i moves to FLUSH. start_i is ignored.
  - FLUSH: pushes the terminal entry when the FIFO is not full, then moves to DRAIN. If lane_cnt > 0, the terminal entry is the partial word: unused lanes are zero, keep = (1<<lane_cnt)-1, last=1. If lane_cnt == 0, the terminal entry is word 0, keep 0, last=1. px_valid_i is ignored.
  - DRAIN: waits for the FIFO to be empty, then moves to IDLE.
- Simultaneous px_valid_i and finish_i in RUN: the pixel is accepted first and is included in the terminal/full word. If that pixel completes a word, the full word is pushed and FLUSH emits the empty last marker.
- FIFO: first-word-fall-through. A push is visible on word_o/word_valid_o the cycle after the push. A pop occurs on word_valid_o && word_ready_i. Push and pop in the same cycle are allowed when full; the net occupancy is unchanged.
- Overflow: a push attempted in RUN with the FIFO full and no simultaneous pop drops the word, and overflow_o is set. The lane counter still wraps. The flag stays set until the next start_i or reset.
- Counter: px_count_o increments on every accepted pixel in RUN and saturates at all-ones.
- Latency: 4th pixel accepted at cycle N gives word_valid_o=1 at N+1 if the FIFO was empty.
- Outputs are registered or driven directly from FIFO storage; there are no combinational paths from px_i to word_o.

Decomposition:
- Package sobel_px_packer_pkg holds:
  - state_t enum {IDLE, RUN, FLUSH, DRAIN};
  - the fifo entry struct {last, keep[LANES], data};
  - default parameter constants.
- Sub-module px_word_fifo: synchronous FWFT FIFO with synchronous active-high reset, parameterised width/depth, and full/empty/count outputs.

Test Plan:
- start, 8 pixels 0x01..0x08 back-to-back, ready=1, finish → words 0x04030201 keep F last 0, 0x08070605 keep F last 0, then 0x00000000 keep 0 last 1; px_count_o=8.
- start, pixels 0xAA,0xBB,0xCC, finish → single word 0x00CCBBAA keep 0x7 last 1; busy_o falls once the FIFO is empty.
- ready=0, 40 pixels (10 words) into FIFO_DEPTH 8 → 8 words held, overflow_o=1, px_count_o=40; releasing ready yields the first 8 words in order.
- 4th pixel coincident with finish_i → full word keep F last 0, then empty last marker; no pixel lost.
- reset_i asserted mid-frame with 3 words queued → next cycle word_valid_o=0, busy_o=0, px_count_o=0; a new frame packs from lane 0.
- px_valid_i pulses while IDLE, and start_i pulses during RUN → no words produced, counter unaffected, frame continues unchanged.

Source files
------------

// File: rtl/sobel_px_packer_pkg.sv
// Shared types and defaults for the sobel pixel-to-word packer.
package sobel_px_packer_pkg;

   localparam int PIXEL_W_DEF    = 8;
   localparam int LANES_DEF      = 4;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int CNT_W_DEF      = 20;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DRAIN
   } state_t;

   typedef struct packed {
      logic                             last;
      logic [LANES_DEF-1:0]             keep;
      logic [PIXEL_W_DEF*LANES_DEF-1:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W_DEF = $bits(fifo_entry_t);

endpackage

// File: rtl/sobel_px_packer_fifo.sv
// First-word-fall-through word FIFO; head is zero while empty.
module px_word_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO still takes a push when the head leaves the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sobel_px_packer.sv
// Packs the sobel core pixel stream into LANES-wide words for a bus writer,
// with a terminal last-tagged entry per frame.
module sobel_px_packer
   import sobel_px_packer_pkg::*;
#(
   parameter int PIXEL_W    = PIXEL_W_DEF,
   parameter int LANES      = LANES_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic                     finish_i,
   input  logic                     px_valid_i,
   input  logic [PIXEL_W-1:0]       px_i,
   output logic [PIXEL_W*LANES-1:0] word_o,
   output logic [LANES-1:0]         word_keep_o,
   output logic                     word_last_o,
   output logic                     word_valid_o,
   input  logic                     word_ready_i,
   output logic                     busy_o,
   output logic                     overflow_o,
   output logic [CNT_W-1:0]         px_count_o
);

   localparam int WW = PIXEL_W * LANES;
   localparam int EW = WW + LANES + 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   state_t            state_q, state_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [WW-1:0]     pack_q, pack_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              ovf_d;
   logic [LANES-1:0]  keep_part;
   logic [EW-1:0]     push_entry;
   logic [EW-1:0]     head;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   px_word_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push    (push),
      .din     (push_entry),
      .pop     (pop),
      .dout    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign word_o       = head[WW-1:0];
   assign word_keep_o  = head[WW +: LANES];
   assign word_last_o  = head[EW-1];
   assign word_valid_o = !fifo_empty;
   assign pop          = word_valid_o && word_ready_i;
   assign busy_o       = (state_q != IDLE);

   always_comb begin
      keep_part = '0;
      for (int i = 0; i < LANES; i++) keep_part[i] = (i < int'(lane_q));
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      cnt_d      = px_count_o;
      ovf_d      = overflow_o;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               lane_d  = '0;
               pack_d  = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         RUN: begin
            if (px_valid_i) begin
               for (int i = 0; i < LANES; i++)
                  if (lane_q == LW'(i)) pack_d[i*PIXEL_W +: PIXEL_W] = px_i;
               if (!(&px_count_o)) cnt_d = px_count_o + 1'b1;
               if (lane_q == LW'(LANES-1)) begin
                  push       = 1'b1;
                  push_entry = {1'b0, {LANES{1'b1}}, pack_d};
                  if (fifo_full && !pop) ovf_d = 1'b1;
                  lane_d     = '0;
                  pack_d     = '0;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
            if (finish_i) state_d = FLUSH;
         end
         FLUSH: begin
            // pack_q is already zero in unused lanes, so it is the payload
            if (fifo_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)) begin
               push       = 1'b1;
               push_entry = {1'b1, keep_part, pack_q};
               lane_d     = '0;
               pack_d     = '0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         pack_q     <= '0;
         px_count_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         px_count_o <= cnt_d;
         overflow_o <= ovf_d;
      end
   end

endmodule
